// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO I/O controller: region base, register
// offsets inside the region and status bit positions.
package mmio_pkg;

  // Default base of the MMIO region; only bits [31:28] take part in decode.
  localparam logic [31:0] MMIO_BASE_DEF = 32'h8000_0000;

  // Register offsets from the region base (low 28 address bits).
  localparam logic [27:0] MMIO_STATUS  = 28'h000_0000;
  localparam logic [27:0] MMIO_RX      = 28'h000_0004;
  localparam logic [27:0] MMIO_TX      = 28'h000_0008;
  localparam logic [27:0] MMIO_CYCLE   = 28'h000_0010;
  localparam logic [27:0] MMIO_INSTRET = 28'h000_0014;
  localparam logic [27:0] MMIO_CNT_CLR = 28'h000_0018;

  // Bit positions inside the status word.
  localparam int STAT_TX_FREE     = 0;
  localparam int STAT_RX_NONEMPTY = 1;

  // Region hit: compare the top address nibble against the base nibble.
  function automatic logic mmio_hit(input logic [3:0] adr_hi, input logic [3:0] base_hi);
    return (adr_hi == base_hi);
  endfunction

endpackage

// File: rtl/mmio_rx_fifo.sv
// RX byte buffer for the MMIO controller.
// With MMIO_RX_FIFO_EN defined it is a DEPTH-entry circular FIFO; otherwise
// it collapses to a single holding register and DEPTH only sizes o_count.
// A push is taken only when there is room (or, in the single-entry build,
// when the held byte leaves in the same cycle); a pop only when non-empty.
module mmio_rx_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [7:0]    i_push_data,
  input  logic          i_pop,
  output logic [7:0]    o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

`ifdef MMIO_RX_FIFO_EN

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_empty   = (r_count == {(AW+1){1'b0}});
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

`else

  logic       r_held;
  logic [7:0] r_data;
  logic       w_do_pop;
  logic       w_do_push;

  assign w_do_pop  = i_pop && r_held;
  assign w_do_push = i_push && (!r_held || w_do_pop);

  // Single holding register; a same-cycle pop and push reloads the new byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_held <= 1'b0;
      r_data <= 8'h00;
    end else if (w_do_push) begin
      r_held <= 1'b1;
      r_data <= i_push_data;
    end else if (w_do_pop) begin
      r_held <= 1'b0;
    end
  end

  assign o_head  = r_data;
  assign o_full  = r_held;
  assign o_empty = !r_held;
  assign o_count = {{AW{1'b0}}, r_held};

`endif

endmodule

// File: rtl/mmio_io_ctrl.sv
// MMIO I/O controller on the core data-memory port.
// Decodes the M-stage access, drives a UART TX byte, buffers UART RX bytes,
// keeps cycle/instret counters and returns registered read data in W.
// Optional feature macro: MMIO_RX_FIFO_EN (multi-entry RX FIFO instead of a
// single holding register).
module mmio_io_ctrl
  import mmio_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
  parameter int          RX_DEPTH  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] mem_adrM,
  input  logic [XLEN-1:0] mem_wdataM,
  input  logic [3:0]      wea,
  input  logic            rd_enM,
  input  logic            instr_retire,
  output logic [XLEN-1:0] dout,
  output logic [7:0]      uart_tx_data,
  output logic            uart_tx_valid,
  input  logic            uart_tx_ready,
  input  logic [7:0]      uart_rx_data,
  input  logic            uart_rx_valid,
  output logic            uart_rx_ready
);

  localparam int RX_AW = $clog2(RX_DEPTH);

  logic [XLEN-1:0] r_dout;
  logic [7:0]      r_tx_data;
  logic            r_tx_valid;
  logic [31:0]     r_cycle;
  logic [31:0]     r_instret;

  logic [27:0]     w_off;
  logic            w_sel;
  logic            w_store;
  logic            w_load;
  logic            w_tx_wr;
  logic            w_cnt_clr;
  logic            w_rx_pop;
  logic            w_rx_push;
  logic [7:0]      w_rx_head;
  logic            w_rx_full;
  logic            w_rx_empty;
  logic [RX_AW:0]  w_rx_count;
  logic            w_rx_nonempty;
  logic [XLEN-1:0] w_rd_data;
  logic            w_unused;

  // Only the low store byte feeds the TX register.
  assign w_unused = ^mem_wdataM[XLEN-1:8];

  assign w_off     = mem_adrM[27:0];
  assign w_sel     = mmio_hit(mem_adrM[XLEN-1:XLEN-4], MMIO_BASE[31:28]);
  assign w_store   = w_sel && (wea != 4'b0000);
  assign w_load    = w_sel && rd_enM;
  assign w_tx_wr   = w_store && (w_off == MMIO_TX);
  assign w_cnt_clr = w_store && (w_off == MMIO_CNT_CLR);
  assign w_rx_pop  = w_load && (w_off == MMIO_RX) && !w_rx_empty;

  // Ready depends on registered occupancy only, never on this cycle's pop.
  assign uart_rx_ready = !w_rx_full;
  assign w_rx_push     = uart_rx_valid && !w_rx_full;
  assign w_rx_nonempty = (w_rx_count != {(RX_AW+1){1'b0}});

  mmio_rx_fifo #(
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_rx_push),
    .i_push_data (uart_rx_data),
    .i_pop       (w_rx_pop),
    .o_head      (w_rx_head),
    .o_full      (w_rx_full),
    .o_empty     (w_rx_empty),
    .o_count     (w_rx_count)
  );

  // Read mux: value that dout captures at the end of the M-stage cycle.
  always_comb begin
    w_rd_data = {XLEN{1'b0}};
    if (w_load) begin
      case (w_off)
        MMIO_STATUS: begin
          w_rd_data[STAT_TX_FREE]     = !r_tx_valid;
          w_rd_data[STAT_RX_NONEMPTY] = w_rx_nonempty;
        end
        MMIO_RX: begin
          if (!w_rx_empty) begin
            w_rd_data[7:0] = w_rx_head;
          end else begin
            w_rd_data = {XLEN{1'b0}};
          end
        end
        MMIO_CYCLE:   w_rd_data[31:0] = r_cycle;
        MMIO_INSTRET: w_rd_data[31:0] = r_instret;
        default:      w_rd_data = {XLEN{1'b0}};
      endcase
    end else begin
      w_rd_data = {XLEN{1'b0}};
    end
  end

  // Registered read data; zero whenever the cycle is not an MMIO load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dout <= {XLEN{1'b0}};
    end else begin
      r_dout <= w_rd_data;
    end
  end

  // TX holding register; stores while a byte is pending (including the
  // handshake cycle) are dropped so the byte stays stable while valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else if (w_tx_wr && !r_tx_valid) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= mem_wdataM[7:0];
    end else if (r_tx_valid && uart_tx_ready) begin
      r_tx_valid <= 1'b0;
    end
  end

  // Free-running cycle and retired-instruction counters; clear wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cycle   <= 32'h0000_0000;
      r_instret <= 32'h0000_0000;
    end else if (w_cnt_clr) begin
      r_cycle   <= 32'h0000_0000;
      r_instret <= 32'h0000_0000;
    end else begin
      r_cycle <= r_cycle + 32'h0000_0001;
      if (instr_retire) begin
        r_instret <= r_instret + 32'h0000_0001;
      end
    end
  end

  assign dout          = r_dout;
  assign uart_tx_data  = r_tx_data;
  assign uart_tx_valid = r_tx_valid;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl: a vector table for single-cycle
// behaviour plus hand sequences for counters, RX buffering and reset.
module tb_mmio_io_ctrl;

`ifdef MMIO_RX_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic [3:0]  wea;
  logic        rd;
  logic        retire;
  logic [31:0] dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mmio_io_ctrl #(
    .XLEN      (32),
    .MMIO_BASE (32'h8000_0000),
    .RX_DEPTH  (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_adrM      (adr),
    .mem_wdataM    (wdata),
    .wea           (wea),
    .rd_enM        (rd),
    .instr_retire  (retire),
    .dout          (dout),
    .uart_tx_data  (tx_data),
    .uart_tx_valid (tx_valid),
    .uart_tx_ready (tx_ready),
    .uart_rx_data  (rx_data),
    .uart_rx_valid (rx_valid),
    .uart_rx_ready (rx_ready)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  wea;
    logic        rd;
    logic        txr;
    logic        rxv;
    logic [7:0]  rxd;
    logic [31:0] e_dout;
    logic        e_txv;
    logic [7:0]  e_txd;
    logic        c_txd;
    logic        e_rxr;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                              input logic r, input logic txr, input logic rxv, input logic [7:0] rxd,
                              input logic [31:0] e_dout, input logic e_txv, input logic [7:0] e_txd,
                              input logic c_txd, input logic e_rxr);
    vec_t v;
    v.adr = a; v.wdata = d; v.wea = we; v.rd = r; v.txr = txr; v.rxv = rxv; v.rxd = rxd;
    v.e_dout = e_dout; v.e_txv = e_txv; v.e_txd = e_txd; v.c_txd = c_txd; v.e_rxr = e_rxr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    adr = 32'h0; wdata = 32'h0; wea = 4'h0; rd = 1'b0; retire = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we, input logic r);
    adr = a; wdata = d; wea = we; rd = r;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic rr;
    rr = FIFO_EN ? 1'b1 : 1'b0;
    vecs[0]  = mk(32'h8000_0008, 32'h0000_0041, 4'hF, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 8'h41, 1'b1, 1'b1);
    vecs[1]  = mk(32'h8000_0008, 32'h0000_0042, 4'hF, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 8'h41, 1'b1, 1'b1);
    vecs[2]  = mk(32'h8000_0000, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 8'h41, 1'b1, 1'b1);
    vecs[3]  = mk(32'h8000_0008, 32'h0000_0043, 4'hF, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1);
    vecs[4]  = mk(32'h8000_0000, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h1, 1'b0, 8'h00, 1'b0, 1'b1);
    vecs[5]  = mk(32'h0000_0008, 32'h0000_0055, 4'hF, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1);
    vecs[6]  = mk(32'h8000_001C, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1);
    vecs[7]  = mk(32'h0000_0000, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 8'h5A, 32'h0, 1'b0, 8'h00, 1'b0, rr);
    vecs[8]  = mk(32'h8000_0000, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h3, 1'b0, 8'h00, 1'b0, rr);
    vecs[9]  = mk(32'h0000_0010, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b0, rr);
    vecs[10] = mk(32'h8000_0004, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h5A, 1'b0, 8'h00, 1'b0, 1'b1);
    vecs[11] = mk(32'h8000_0004, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1);
    vecs[12] = mk(32'h8000_0000, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h1, 1'b0, 8'h00, 1'b0, 1'b1);
    vecs[13] = mk(32'h8000_000C, 32'h0000_00FF, 4'hF, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1);
    vecs[14] = mk(32'h8000_0008, 32'h1234_5677, 4'h1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 8'h77, 1'b1, 1'b1);
    vecs[15] = mk(32'h0000_0000, 32'h0,         4'h0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1);
    vecs[16] = mk(32'h8000_0008, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1);
    vecs[17] = mk(32'h8000_0018, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1);
    vecs[18] = mk(32'h8000_0005, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Reset state.
    idle();
    rst = 1'b0;
    tick();
    tick();
    chk("rst_dout", dout, 32'h0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
    chk("rst_rx_ready", {31'b0, rx_ready}, 32'h1);

    // First cycle counter read right after release.
    rst = 1'b1;
    bus(32'h8000_0010, 32'h0, 4'h0, 1'b1);
    tick();
    checks++;
    if (dout > 32'd2) begin
      errors++;
      $display("FAIL cycle_after_reset: got 0x%08h expected at most 0x00000002", dout);
    end

    // Table-driven single-cycle vectors.
    for (int i = 0; i < NV; i++) begin
      bus(vecs[i].adr, vecs[i].wdata, vecs[i].wea, vecs[i].rd);
      tx_ready = vecs[i].txr;
      rx_valid = vecs[i].rxv;
      rx_data  = vecs[i].rxd;
      tick();
      chk($sformatf("vec%0d_dout", i), dout, vecs[i].e_dout);
      chk($sformatf("vec%0d_tx_valid", i), {31'b0, tx_valid}, {31'b0, vecs[i].e_txv});
      chk($sformatf("vec%0d_rx_ready", i), {31'b0, rx_ready}, {31'b0, vecs[i].e_rxr});
      if (vecs[i].c_txd) begin
        chk($sformatf("vec%0d_tx_data", i), {24'b0, tx_data}, {24'b0, vecs[i].e_txd});
      end
    end
    idle();

    // Counters: clear, 5 retires, then read instret and cycle.
    bus(32'h8000_0018, 32'hDEAD_BEEF, 4'hF, 1'b0);
    tick();
    idle();
    retire = 1'b1;
    repeat (5) tick();
    retire = 1'b0;
    bus(32'h8000_0014, 32'h0, 4'h0, 1'b1);
    tick();
    chk("instret_5", dout, 32'd5);
    bus(32'h8000_0010, 32'h0, 4'h0, 1'b1);
    tick();
    chk("cycle_after_clear", dout, 32'd6);

    // Clear in the same cycle as a retire: clear wins.
    bus(32'h8000_0018, 32'h0, 4'hF, 1'b0);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    bus(32'h8000_0014, 32'h0, 4'h0, 1'b1);
    tick();
    chk("instret_clr_prio", dout, 32'd0);
    bus(32'h8000_0010, 32'h0, 4'h0, 1'b1);
    tick();
    chk("cycle_clr_prio", dout, 32'd1);
    // Read returns the pre-edge value even while retiring.
    bus(32'h8000_0014, 32'h0, 4'h0, 1'b1);
    retire = 1'b1;
    tick();
    chk("instret_pre_edge", dout, 32'd0);
    retire = 1'b0;
    tick();
    chk("instret_after_retire", dout, 32'd1);
    idle();
    tick();

`ifdef MMIO_RX_FIFO_EN
    // Fill the FIFO to full.
    for (int i = 1; i <= 8; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(i);
      tick();
      chk($sformatf("fill%0d_rx_ready", i), {31'b0, rx_ready}, (i < 8) ? 32'h1 : 32'h0);
    end
    rx_data = 8'h09;
    tick();
    chk("full_drop_rx_ready", {31'b0, rx_ready}, 32'h0);
    rx_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus(32'h8000_0004, 32'h0, 4'h0, 1'b1);
      tick();
      chk($sformatf("drain%0d_dout", i), dout, 32'(i));
      chk($sformatf("drain%0d_rx_ready", i), {31'b0, rx_ready}, 32'h1);
    end
    tick();
    chk("drain_empty_dout", dout, 32'h0);
    bus(32'h8000_0000, 32'h0, 4'h0, 1'b1);
    tick();
    chk("drain_status", dout, 32'h1);
    idle();

    // Simultaneous push and pop with three entries.
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'hA1 + 8'(i);
      tick();
    end
    bus(32'h8000_0004, 32'h0, 4'h0, 1'b1);
    rx_data = 8'hA4;
    tick();
    chk("pushpop_dout", dout, 32'hA1);
    rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("pushpop_order%0d", i), dout, 32'hA2 + 32'(i));
    end
    bus(32'h8000_0000, 32'h0, 4'h0, 1'b1);
    tick();
    chk("pushpop_status", dout, 32'h1);
    idle();
`else
    // Single-entry holding register.
    rx_valid = 1'b1;
    rx_data  = 8'h11;
    tick();
    chk("hold_rx_ready", {31'b0, rx_ready}, 32'h0);
    rx_data = 8'h22;
    tick();
    chk("hold_drop_rx_ready", {31'b0, rx_ready}, 32'h0);
    rx_valid = 1'b0;
    bus(32'h8000_0000, 32'h0, 4'h0, 1'b1);
    tick();
    chk("hold_status", dout, 32'h3);
    bus(32'h8000_0004, 32'h0, 4'h0, 1'b1);
    tick();
    chk("hold_pop_dout", dout, 32'h11);
    chk("hold_pop_rx_ready", {31'b0, rx_ready}, 32'h1);
    tick();
    chk("hold_empty_dout", dout, 32'h0);
    bus(32'h8000_0000, 32'h0, 4'h0, 1'b1);
    tick();
    chk("hold_empty_status", dout, 32'h1);
    idle();
`endif

    // Reset in the middle of a transfer discards TX and RX state.
    bus(32'h8000_0008, 32'h0000_0099, 4'hF, 1'b0);
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    tick();
    chk("mid_tx_valid", {31'b0, tx_valid}, 32'h1);
    rx_valid = 1'b0;
    bus(32'h8000_0000, 32'h0, 4'h0, 1'b1);
    tick();
    chk("mid_status", dout, 32'h2);
    rst = 1'b0;
    tick();
    chk("mid_rst_dout", dout, 32'h0);
    chk("mid_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("mid_rst_tx_data", {24'b0, tx_data}, 32'h0);
    chk("mid_rst_rx_ready", {31'b0, rx_ready}, 32'h1);
    rst = 1'b1;
    tick();
    chk("post_rst_status", dout, 32'h1);
    bus(32'h8000_0004, 32'h0, 4'h0, 1'b1);
    tick();
    chk("post_rst_rx_empty", dout, 32'h0);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
Memory-mapped I/O controller directly downstream of the core's data-memory port. It consumes the M-stage address, write data and byte-write enables, and decodes the MMIO region. It drives a UART TX byte stream, buffers UART RX bytes, and maintains cycle and retired-instruction counters. It returns registered read data aligned with the W-stage `din` input.

Parameters:
- MMIO_BASE, 32'h8000_0000, base of the MMIO region; the region is selected when adr[31:28] == MMIO_BASE[31:28].
- RX_DEPTH, 8, RX FIFO depth in bytes; power of two, minimum 2.
- XLEN, 32, data and address width.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-low
- mem_adrM  in  XLEN  M-stage data address
- mem_wdataM  in  XLEN  M-stage store data
- wea  in  4  byte write enables; any nonzero value is a store
- rd_enM  in  1  M-stage load qualifier
- instr_retire  in  1  one instruction retired this cycle
- dout  out  XLEN  registered MMIO read data, fed to the W-stage mux
- uart_tx_data  out  8  TX byte
- uart_tx_valid  out  1  TX byte valid
- uart_tx_ready  in  1  UART transmitter accepts the byte
- uart_rx_data  in  8  received byte
- uart_rx_valid  in  1  received byte valid
- uart_rx_ready  out  1  controller can accept a byte

Behaviour:
- Reset (rst == 0 at a clk edge):
  - dout = 0, uart_tx_valid = 0, uart_tx_data = 0.
  - Both counters = 0; RX FIFO empty.
  - Reset mid-transfer discards the pending TX byte and all RX contents.
- Address map (offset from MMIO_BASE):
  - 0x00 status, read-only: {30'b0, rx_nonempty, tx_free}, where tx_free = !uart_tx_valid.
  - 0x04 RX data, read-only: {24'b0, head byte}. Pops the FIFO.
  - 0x08 TX data, write-only: loads wdata[7:0].
  - 0x10 cycle counter, read-only.
  - 0x14 instret counter, read-only.
  - 0x18 counter clear, write-only; data is ignored.
- Other MMIO offsets: reads return 0; writes are ignored.
- Addresses outside the MMIO region: dout = 0, no side effects.
- Read latency: exactly 1 cycle. dout is registered at the edge that ends the M-stage cycle, so it is valid during W.
  - Without rd_enM, dout is loaded with 0.
- RX pop: occurs at the same edge as the read, only when rd_enM is high, the offset is 0x04 and the FIFO is non-empty.
  - Reading 0x04 while the FIFO is empty returns 0 and does not pop.
- RX push: occurs on uart_rx_valid && uart_rx_ready.
  - uart_rx_ready = !full. This is combinational from registered state and does not depend on the same-cycle pop.
  - Simultaneous push and pop: occupancy is unchanged and data order is preserved.
  - Pointers wrap modulo RX_DEPTH; occupancy counter is log2(RX_DEPTH)+1 bits.
- TX load: a write to 0x08 is accepted only when uart_tx_valid == 0. Then uart_tx_data <= wdata[7:0] and uart_tx_valid <= 1.
  - A write while uart_tx_valid == 1 is dropped. This includes the handshake cycle: software polls status.
  - uart_tx_valid clears the edge after uart_tx_valid && uart_tx_ready.
  - uart_tx_data is stable while uart_tx_valid is high.
- Counters are 32-bit and wrap 0xFFFF_FFFF -> 0.
  - cycle_cnt increments every cycle.
  - instret_cnt increments when instr_retire is high.
  - A clear write has priority over the increment in that cycle: both counters become 0.
- Reads of the counters return the pre-edge value.

Optional Feature:
- Macro: MMIO_RX_FIFO_EN.
- Defined: the RX buffer is a RX_DEPTH-entry FIFO as described above.
- Undefined: the RX buffer is a single-entry holding register and RX_DEPTH is unused.
  - uart_rx_ready = !held.
  - A pop and a push in the same cycle are both honoured: the register reloads with the new byte.
  - Status and read semantics are otherwise identical.

Decomposition:
- Shared package mmio_pkg holds:
  - MMIO_BASE default;
  - offset constants MMIO_STATUS, MMIO_RX, MMIO_TX, MMIO_CYCLE, MMIO_INSTRET, MMIO_CNT_CLR;
  - status bit indices.
- One sub-module, mmio_rx_fifo: parameterised depth, push/pop/full/empty/count, synchronous active-low reset.
- The single-entry variant lives inside it under the macro.

Test Plan:
- Reset check: hold rst = 0 for 2 cycles, then release -> dout = 0, uart_tx_valid = 0, uart_rx_ready = 1; read 0x10 immediately -> dout shows a small count (at most 2).
- TX handshake: store 0x41 to 0x8000_0008 with uart_tx_ready = 0 -> uart_tx_valid = 1 and data 0x41.
  - A second store of 0x42 is dropped.
  - Raise ready for 1 cycle -> valid = 0 next cycle; status reads 0x1.
- RX fill (MMIO_RX_FIFO_EN): push bytes 0x01..0x08 -> uart_rx_ready = 0 after the 8th byte.
  - Read 0x04 8 times -> dout = 0x01..0x08 in order, each 1 cycle after rd_enM.
  - A 9th read returns 0 and status bit1 = 0.
- Simultaneous push/pop with 3 entries -> count stays 3 and order is preserved.
- Counters: pulse instr_retire 5 times -> instret = 5; a clear store in the same cycle as a retire -> both counters 0.
- Address decode: read 0x8000_001C and 0x0000_0010 -> dout = 0 with no pop; store to 0x0000_0008 -> no TX.
